manual_key_ctrl: RTL

Front-panel manual-key sequencer for the PDP-8/I manual timing generator. It synchronises and debounces the raw console keys and arbitrates simultaneous presses. It latches the selected manual function, then drives the timing generator's key-request input and holds it until the final manual time pulse returns. Finally it locks out further keys until the panel is released. STOP is handled locally and never starts a manual timing cycle.

---
 rtl/manual_key_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/manual_key_ctrl.sv
// Front-panel manual-key sequencer: synchronises, debounces and arbitrates console keys,
// then issues one manual timing request per accepted press and waits for panel release.
module manual_key_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned MFT_TIMEOUT     = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_load_add,
    input  logic       key_dep,
    input  logic       key_exam,
    input  logic       key_cont,
    input  logic       key_stop,
    input  logic       run,
    input  logic       mftp2,
    output logic       mft_key,
    output logic [2:0] func,
    output logic       func_valid,
    output logic       stop_req,
    output logic       lockout,
    output logic       mft_err
);

    localparam int unsigned CNT_TOP = (DEBOUNCE_CYCLES > MFT_TIMEOUT) ? DEBOUNCE_CYCLES
                                                                      : MFT_TIMEOUT;
    localparam int unsigned CW = $clog2(CNT_TOP + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MFT_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(CNT_TOP);

    typedef enum logic [2:0] {
        StIdle,
        StDebounce,
        StFire,
        StWaitP2,
        StRelease
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [5:0]    sync1_q;
    logic [5:0]    sk_q;

    logic [5:0]    key_raw;
    logic [5:0]    eligible;
    logic [2:0]    pick;
    logic          latched_key;
    logic          any_key;
    logic [CW-1:0] cnt_inc;

    // Bit order: 0 START, 1 LOAD ADD, 2 DEP, 3 EXAM, 4 CONT, 5 STOP (bit i is func code i+1).
    assign key_raw = {key_stop, key_cont, key_exam, key_dep, key_load_add, key_start};
    assign any_key = |sk_q;
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    assign lockout = (state_q != StIdle);

    always_comb begin
        eligible = run ? {sk_q[5], 5'b0} : sk_q;
        pick = 3'd0;
        if (eligible[5])      pick = 3'd6;
        else if (eligible[0]) pick = 3'd1;
        else if (eligible[1]) pick = 3'd2;
        else if (eligible[2]) pick = 3'd3;
        else if (eligible[3]) pick = 3'd4;
        else if (eligible[4]) pick = 3'd5;
    end

    always_comb begin
        latched_key = 1'b0;
        case (func)
            3'd1:    latched_key = sk_q[0];
            3'd2:    latched_key = sk_q[1];
            3'd3:    latched_key = sk_q[2];
            3'd4:    latched_key = sk_q[3];
            3'd5:    latched_key = sk_q[4];
            3'd6:    latched_key = sk_q[5];
            default: latched_key = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sync1_q    <= '0;
            sk_q       <= '0;
            mft_key    <= 1'b0;
            func       <= 3'd0;
            func_valid <= 1'b0;
            stop_req   <= 1'b0;
            mft_err    <= 1'b0;
        end else begin
            sync1_q  <= key_raw;
            sk_q     <= sync1_q;
            stop_req <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pick != 3'd0) begin
                        func    <= pick;
                        mft_err <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StDebounce;
                    end
                end
                StDebounce: begin
                    if (!latched_key) begin
                        func    <= 3'd0;
                        state_q <= StIdle;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_q <= '0;
                        if (func == 3'd6) begin
                            stop_req <= 1'b1;
                            state_q  <= StRelease;
                        end else begin
                            state_q <= StFire;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StFire: begin
                    mft_key    <= 1'b1;
                    func_valid <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= StWaitP2;
                end
                StWaitP2: begin
                    if (mftp2 || cnt_q == TO_LAST) begin
                        mft_key    <= 1'b0;
                        func_valid <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= StRelease;
                        if (!mftp2) mft_err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StRelease: begin
                    // Any key bounce restarts the release window.
                    if (any_key) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        func    <= 3'd0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
